// File: rtl/mlaccel_qpi_resp.sv
// mlaccel_qpi_resp: device-side QPI responder that oversamples host pins and moves bytes to/from the core.
// Define QPI_RXFIFO_EN for a 4-entry rx FIFO instead of the single holding register. DUMMY_SLOTS must be >= 1.
module mlaccel_qpi_resp #(
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_SLOTS = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_di,
  output logic [3:0] qpi_do,
  output logic       qpi_oe,
  output logic       qpi_rdy,
  output logic       qpi_err,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       xfer_end,
  input  logic       tx_start,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic [1:0] dbg_state
);
  // Handshakes: a byte moves on any clock edge where valid && ready are both high.
  // rx_valid holds until accepted; tx_ready is a single-cycle strobe at slot start.
  typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, TURN = 2'd2, TX = 2'd3} state_t;

  localparam logic [5:0] PINS_IDLE = 6'b110000;
  localparam logic [7:0] LAST_SLOT = 8'(DUMMY_SLOTS - 1);

  state_t     state, state_n;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] pins, pins_d;
  logic       csb_fall, csb_rise, clk_rise, clk_fall, byte_done;
  logic       have_hi, first_flag;
  logic [3:0] hi_nib, tx_lo;
  logic [7:0] rx_byte, slot_cnt;
  logic       slot_start, drive_lo, push_req, clr_err, set_first, slot_clr, slot_inc, go_idle;
  logic       rx_full, rx_pop, rx_accept, rx_ovf;

  // Pin vector {csb, clk, di} is synchronised as one word so edges and data stay aligned.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PINS_IDLE;
      pins_d <= PINS_IDLE;
    end else begin
      sync_q[0] <= {qpi_csb, qpi_clk, qpi_di};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pins_d <= pins;
    end
  end

  assign pins      = sync_q[SYNC_STAGES-1];
  assign csb_fall  = pins_d[5] & ~pins[5];
  assign csb_rise  = ~pins_d[5] & pins[5];
  assign clk_rise  = ~pins_d[4] & pins[4];
  assign clk_fall  = pins_d[4] & ~pins[4];
  assign byte_done = clk_fall & have_hi;
  // pins_d carries the io value that was present while clk held its previous level.
  assign rx_byte   = {hi_nib, pins_d[3:0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    slot_start = 1'b0;
    drive_lo   = 1'b0;
    push_req   = 1'b0;
    clr_err    = 1'b0;
    set_first  = 1'b0;
    slot_clr   = 1'b0;
    slot_inc   = 1'b0;
    go_idle    = 1'b0;
    case (state)
      IDLE: if (csb_fall) begin
        state_n   = RX;
        clr_err   = 1'b1;
        set_first = 1'b1;
      end
      RX: begin
        push_req = byte_done;
        if (tx_start) begin
          state_n  = TURN;
          slot_clr = 1'b1;
        end
      end
      TURN: if (byte_done) begin
        // The fall that closes the last dummy slot also opens the first tx slot.
        if (slot_cnt == LAST_SLOT) begin
          state_n    = TX;
          slot_start = 1'b1;
        end else begin
          slot_inc = 1'b1;
        end
      end
      TX: begin
        slot_start = clk_fall;
        drive_lo   = clk_rise;
      end
      default: state_n = IDLE;
    endcase
    if (csb_rise) begin
      state_n    = IDLE;
      go_idle    = 1'b1;
      slot_start = 1'b0;
      drive_lo   = 1'b0;
      push_req   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      have_hi    <= 1'b0;
      hi_nib     <= '0;
      first_flag <= 1'b0;
      slot_cnt   <= '0;
      tx_lo      <= '0;
      qpi_do     <= '0;
      qpi_oe     <= 1'b0;
      qpi_err    <= 1'b0;
      xfer_end   <= 1'b0;
    end else begin
      xfer_end <= csb_rise;
      if (state == IDLE || go_idle || clk_fall) begin
        have_hi <= 1'b0;
      end else if (clk_rise) begin
        have_hi <= 1'b1;
        hi_nib  <= pins_d[3:0];
      end
      if (set_first)     first_flag <= 1'b1;
      else if (push_req) first_flag <= 1'b0;
      if (clr_err)                                  qpi_err <= 1'b0;
      else if (rx_ovf || (slot_start && !tx_valid)) qpi_err <= 1'b1;
      if (slot_clr)      slot_cnt <= '0;
      else if (slot_inc) slot_cnt <= slot_cnt + 8'd1;
      if (go_idle) begin
        qpi_oe <= 1'b0;
        qpi_do <= '0;
      end else if (slot_start) begin
        // Underrun fills the slot with all ones.
        qpi_oe <= 1'b1;
        qpi_do <= tx_valid ? tx_data[7:4] : 4'hF;
        tx_lo  <= tx_valid ? tx_data[3:0] : 4'hF;
      end else if (drive_lo) begin
        qpi_do <= tx_lo;
      end
    end
  end

  assign tx_ready  = slot_start & tx_valid;
  assign qpi_rdy   = (state == IDLE) && !rx_valid;
  assign dbg_state = state;

  assign rx_pop    = rx_valid & rx_ready;
  assign rx_accept = push_req & (~rx_full | rx_pop);
  assign rx_ovf    = push_req & ~rx_accept;

`ifdef QPI_RXFIFO_EN
  logic [8:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rx_accept) begin
        fifo_mem[wr_ptr] <= {first_flag, rx_byte};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (rx_pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(rx_accept) - 3'(rx_pop);
    end
  end

  assign rx_full             = (fifo_cnt == 3'd4);
  assign rx_valid            = (fifo_cnt != 3'd0);
  assign {rx_first, rx_data} = fifo_mem[rd_ptr];
`else
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_first <= 1'b0;
    end else if (rx_accept) begin
      rx_valid <= 1'b1;
      rx_data  <= rx_byte;
      rx_first <= first_flag;
    end else if (rx_pop) begin
      rx_valid <= 1'b0;
    end
  end

  assign rx_full = rx_valid;
`endif

endmodule

// File: tb/tb_mlaccel_qpi_resp.sv
// Bench for mlaccel_qpi_resp: host pin driver, core-side rx monitor, and a byte-level reference model.
module tb_mlaccel_qpi_resp;
  localparam int HALF = 6;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd2;
`ifdef QPI_RXFIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       qpi_csb, qpi_clk;
  logic [3:0] qpi_di, qpi_do;
  logic       qpi_oe, qpi_rdy, qpi_err;
  logic       rx_valid, rx_ready, rx_first;
  logic [7:0] rx_data;
  logic       xfer_end, tx_start, tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic [1:0] dbg_state;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt = 0;
  int txr_cnt  = 0;

  // clock / reset
  always #5 clock = ~clock;

  mlaccel_qpi_resp dut (
    .clock(clock), .resetn(resetn), .qpi_csb(qpi_csb), .qpi_clk(qpi_clk), .qpi_di(qpi_di),
    .qpi_do(qpi_do), .qpi_oe(qpi_oe), .qpi_rdy(qpi_rdy), .qpi_err(qpi_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_first(rx_first),
    .xfer_end(xfer_end), .tx_start(tx_start), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .dbg_state(dbg_state)
  );

  // core-side monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_first, rx_data});
    if (xfer_end) xfer_cnt++;
    if (tx_ready && tx_valid) txr_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Reference model: bytes of one write transaction, first flagged; a stalled consumer keeps only cap.
  function automatic void model_write(input logic [7:0] b[$], input int cap, input bit ready,
                                      output bit ovf);
    ovf = 1'b0;
    foreach (b[i]) begin
      if (ready || i < cap) exp_q.push_back({(i == 0), b[i]});
      else ovf = 1'b1;
    end
  endfunction

  // host driver tasks
  task automatic half();
    repeat (HALF) @(posedge clock);
    #1;
  endtask

  task automatic host_begin();
    qpi_csb = 1'b0;
    half();
  endtask

  task automatic host_byte(input logic [7:0] b);
    qpi_clk = 1'b0; qpi_di = b[7:4]; half();
    qpi_clk = 1'b1; qpi_di = b[3:0]; half();
  endtask

  task automatic host_close_byte();
    qpi_clk = 1'b0; qpi_di = 4'($urandom_range(0, 15)); half();
    qpi_clk = 1'b1; half();
  endtask

  task automatic host_end();
    qpi_csb = 1'b1;
    half();
    half();
  endtask

  task automatic host_write(input logic [7:0] b[$]);
    host_begin();
    foreach (b[i]) host_byte(b[i]);
    host_close_byte();
    host_end();
  endtask

  // Closes the last command byte, lets the core request turnaround, and clocks one dummy slot.
  task automatic host_turn(output logic oe_seen);
    logic oe_a;
    qpi_clk = 1'b0; qpi_di = 4'($urandom_range(0, 15)); half();
    oe_a = qpi_oe;
    tx_start = 1'b1; @(posedge clock); #1; tx_start = 1'b0;
    half();
    qpi_clk = 1'b1; half();
    oe_seen = oe_a | qpi_oe;
  endtask

  task automatic host_read_byte(input logic v, input logic [7:0] d, output logic [7:0] q,
                                output logic oe);
    tx_valid = v; tx_data = d;
    qpi_clk = 1'b0; half();
    q[7:4] = qpi_do; oe = qpi_oe;
    qpi_clk = 1'b1; half();
    q[3:0] = qpi_do; oe = oe & qpi_oe;
  endtask

  task automatic test_reset();
    resetn = 1'b0; qpi_csb = 1'b1; qpi_clk = 1'b1; qpi_di = '0;
    rx_ready = 1'b0; tx_start = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (4) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_tests++; if (qpi_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b exp 0", qpi_oe); end
    n_tests++; if (qpi_do !== 4'h0) begin n_fail++; $display("FAIL reset_do got %h exp 0", qpi_do); end
    n_tests++; if (qpi_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b exp 1", qpi_rdy); end
    n_tests++; if (qpi_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", qpi_err); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    n_tests++; if (rx_first !== 1'b0) begin n_fail++; $display("FAIL reset_rx_first got %b exp 0", rx_first); end
    n_tests++; if (xfer_end !== 1'b0) begin n_fail++; $display("FAIL reset_xfer_end got %b exp 0", xfer_end); end
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready got %b exp 0", tx_ready); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_cmd_write();
    logic [7:0] bytes[$];
    bit ovf;
    int x0;
    for (int it = 0; it < 4; it++) begin
      bytes.delete(); got_q.delete(); exp_q.delete();
      if (it == 0) bytes = '{8'h21, 8'h01, 8'h00, 8'h02, 8'h00};
      else repeat ($urandom_range(1, 6)) bytes.push_back(8'($urandom));
      model_write(bytes, RX_CAP, 1'b1, ovf);
      x0 = xfer_cnt; rx_ready = 1'b1;
      host_write(bytes);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL write_count it%0d got %0d exp %0d", it, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL write_beat it%0d[%0d] got %h exp %h", it, i, got_q[i], exp_q[i]); end
      end
      n_tests++; if (qpi_err !== ovf) begin n_fail++; $display("FAIL write_err it%0d got %b exp %b", it, qpi_err, ovf); end
      n_tests++; if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL write_xfer_end it%0d got %0d exp 1", it, xfer_cnt - x0); end
    end
  endtask

  task automatic test_read_turnaround();
    logic [7:0] cmd[$];
    logic [7:0] rsp[$];
    logic [7:0] q;
    logic oe, oe_turn;
    bit ovf;
    int x0, t0;
    for (int it = 0; it < 4; it++) begin
      cmd.delete(); rsp.delete(); got_q.delete(); exp_q.delete();
      if (it == 0) begin
        cmd = '{8'h23, 8'h00, 8'h00, 8'h0A};
        rsp = '{8'hA5, 8'h00};
      end else begin
        repeat ($urandom_range(1, 3)) cmd.push_back(8'($urandom));
        repeat ($urandom_range(1, 3)) rsp.push_back(8'($urandom));
      end
      model_write(cmd, RX_CAP, 1'b1, ovf);
      x0 = xfer_cnt; t0 = txr_cnt; rx_ready = 1'b1;
      host_begin();
      foreach (cmd[i]) host_byte(cmd[i]);
      host_turn(oe_turn);
      n_tests++; if (oe_turn !== 1'b0) begin n_fail++; $display("FAIL read_turn_oe it%0d got %b exp 0", it, oe_turn); end
      n_tests++; if (dbg_state !== ST_TURN) begin n_fail++; $display("FAIL read_turn_state it%0d got %0d exp %0d", it, dbg_state, ST_TURN); end
      foreach (rsp[i]) begin
        host_read_byte(1'b1, rsp[i], q, oe);
        n_tests++; if (q !== rsp[i]) begin n_fail++; $display("FAIL read_data it%0d[%0d] got %h exp %h", it, i, q, rsp[i]); end
        n_tests++; if (oe !== 1'b1) begin n_fail++; $display("FAIL read_oe it%0d[%0d] got %b exp 1", it, i, oe); end
      end
      tx_valid = 1'b0;
      host_end();
      n_tests++; if (qpi_oe !== 1'b0) begin n_fail++; $display("FAIL read_end_oe it%0d got %b exp 0", it, qpi_oe); end
      n_tests++; if (qpi_err !== 1'b0) begin n_fail++; $display("FAIL read_err it%0d got %b exp 0", it, qpi_err); end
      n_tests++; if (txr_cnt - t0 != rsp.size()) begin n_fail++; $display("FAIL read_tx_ready it%0d got %0d exp %0d", it, txr_cnt - t0, rsp.size()); end
      n_tests++; if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL read_xfer_end it%0d got %0d exp 1", it, xfer_cnt - x0); end
      n_tests++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL read_cmd_count it%0d got %0d exp %0d", it, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL read_cmd_beat it%0d[%0d] got %h exp %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] q, d;
    logic oe, oe_turn;
    rx_ready = 1'b1;
    host_begin();
    host_byte(8'($urandom));
    host_turn(oe_turn);
    host_read_byte(1'b0, 8'($urandom), q, oe);
    n_tests++; if (q !== 8'hFF) begin n_fail++; $display("FAIL underrun_data got %h exp ff", q); end
    n_tests++; if (qpi_err !== 1'b1) begin n_fail++; $display("FAIL underrun_err got %b exp 1", qpi_err); end
    d = 8'($urandom);
    host_read_byte(1'b1, d, q, oe);
    n_tests++; if (q !== d) begin n_fail++; $display("FAIL underrun_recover got %h exp %h", q, d); end
    tx_valid = 1'b0;
    host_end();
    n_tests++; if (qpi_err !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got %b exp 1", qpi_err); end
    host_begin();
    n_tests++; if (qpi_err !== 1'b0) begin n_fail++; $display("FAIL underrun_clear got %b exp 0", qpi_err); end
    host_end();
  endtask

  task automatic test_overflow();
    logic [7:0] bytes[$];
    bit ovf;
    got_q.delete(); exp_q.delete();
    repeat (RX_CAP + 1) bytes.push_back(8'($urandom));
    model_write(bytes, RX_CAP, 1'b0, ovf);
    rx_ready = 1'b0;
    host_write(bytes);
    n_tests++; if (qpi_err !== ovf) begin n_fail++; $display("FAIL overflow_err got %b exp %b", qpi_err, ovf); end
    n_tests++; if (qpi_rdy !== 1'b0) begin n_fail++; $display("FAIL overflow_rdy_held got %b exp 0", qpi_rdy); end
    rx_ready = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL overflow_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL overflow_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (qpi_rdy !== 1'b1) begin n_fail++; $display("FAIL overflow_rdy_drained got %b exp 1", qpi_rdy); end
  endtask

  task automatic test_abort();
    logic [7:0] b0;
    got_q.delete(); exp_q.delete();
    b0 = 8'($urandom);
    exp_q.push_back({1'b1, b0});
    rx_ready = 1'b1;
    host_begin();
    host_byte(b0);
    host_byte(8'($urandom));
    qpi_csb = 1'b1;
    half();
    half();
    n_tests++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL abort_count got %0d exp 1", got_q.size());
    end else begin
      n_tests++;
      if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL abort_beat got %h exp %h", got_q[0], exp_q[0]); end
    end
    n_tests++; if (qpi_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe got %b exp 0", qpi_oe); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state got %0d exp %0d", dbg_state, ST_IDLE); end
    n_tests++; if (qpi_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_rdy got %b exp 1", qpi_rdy); end
    n_tests++; if (qpi_err !== 1'b0) begin n_fail++; $display("FAIL abort_err got %b exp 0", qpi_err); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] bytes[$];
    logic oe_turn;
    bit ovf;
    rx_ready = 1'b1;
    host_begin();
    host_byte(8'($urandom));
    host_turn(oe_turn);
    tx_valid = 1'b1; tx_data = 8'($urandom);
    qpi_clk = 1'b0;
    half();
    n_tests++; if (qpi_oe !== 1'b1) begin n_fail++; $display("FAIL midtx_oe_before got %b exp 1", qpi_oe); end
    resetn = 1'b0;
    #1;
    n_tests++; if (qpi_oe !== 1'b0) begin n_fail++; $display("FAIL midtx_oe_async got %b exp 0", qpi_oe); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midtx_state got %0d exp %0d", dbg_state, ST_IDLE); end
    n_tests++; if (qpi_rdy !== 1'b1) begin n_fail++; $display("FAIL midtx_rdy got %b exp 1", qpi_rdy); end
    qpi_csb = 1'b1; qpi_clk = 1'b1; tx_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    half();
    got_q.delete(); exp_q.delete();
    repeat ($urandom_range(2, 5)) bytes.push_back(8'($urandom));
    model_write(bytes, RX_CAP, 1'b1, ovf);
    host_write(bytes);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midtx_after_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midtx_after_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (qpi_err !== 1'b0) begin n_fail++; $display("FAIL midtx_after_err got %b exp 0", qpi_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[$];
    bit ovf;
    int x0;
    got_q.delete(); exp_q.delete();
    x0 = xfer_cnt; rx_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      bytes.delete();
      repeat ($urandom_range(1, 5)) bytes.push_back(8'($urandom));
      model_write(bytes, RX_CAP, 1'b1, ovf);
      host_write(bytes);
    end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (xfer_cnt - x0 != 3) begin n_fail++; $display("FAIL b2b_xfer_end got %0d exp 3", xfer_cnt - x0); end
  endtask

  initial begin
    test_reset();
    test_cmd_write();
    test_read_turnaround();
    test_underrun();
    test_overflow();
    test_abort();
    test_reset_mid_tx();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
